mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 1-bit output channel among 4 requesters.
- Drives the select pair (s1, s0) of the team's two-level 4:1 mux cell and contains that mux datapath internally.
- Bursts are bounded by MAX_BURST so no requester can hold the channel indefinitely.
- Sits between four bit-serial producers and a single downstream consumer using a valid/ready handshake.

Parameters:
- MAX_BURST, 4, maximum transfers per grant; legal range 1..2^CNT_W.
- CNT_W, 2, width of the burst counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  4  request per requester; held high while the requester has data.
- d  input  4  data bit per requester; d[k] belongs to requester k.
- out_ready  input  1  consumer accepts out_data this cycle.
- gnt  output  4  one-hot grant, registered.
- s1  output  1  mux select, registered.
- s0  output  1  mux select, registered.
- out_data  output  1  muxed data bit.
- out_valid  output  1  out_data valid this cycle.
- ack  output  4  per-requester transfer strobe.
- busy  output  1  high while in GRANT state.

Behaviour:
- Select encoding (fixed by the mux cell):
  - First stage picks i0/i1 and i2/i3 with s1; second stage picks between them with s0.
  - Requester k is therefore selected by s0 = k[1], s1 = k[0].
  - Mapping: req0 -> s0=0,s1=0; req1 -> 0,1; req2 -> 1,0; req3 -> 1,1.
- State: IDLE, GRANT. Registers: cur[1:0], ptr[1:0], cnt[CNT_W-1:0].
- Reset (async, immediate, including mid-burst):
  - state=IDLE, gnt=0000, s1=s0=0, cnt=0, ptr=0, cur=0.
  - Combinational outputs follow: out_valid=0, ack=0000, busy=0, out_data=d[0].
- IDLE:
  - If req != 0 at a clock edge, grant the first asserted requester scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At that edge: cur=winner, gnt=onehot(winner), {s0,s1}=winner, cnt=0, go to GRANT.
  - If req == 0, remain in IDLE with all outputs at their reset values.
  - Latency: req rising seen at edge N gives gnt/out_valid high after edge N.
- GRANT:
  - out_valid = req[cur].
  - xfer = out_valid & out_ready.
  - ack[cur] = xfer; all other ack bits 0.
  - out_data = d[cur], purely combinational through the mux, no register.
  - On xfer with cnt != MAX_BURST-1: cnt increments, stay in GRANT.
  - Release at the edge where xfer and cnt == MAX_BURST-1, or where req[cur] == 0 (no xfer possible that cycle). Both conditions together count as one release.
  - On release: state=IDLE, gnt=0000, ptr=cur+1 mod 4, cnt=0; s1/s0 hold their last value.
  - Exactly one bubble cycle (IDLE) always separates consecutive grants, even when other requests are pending.
- Other rules:
  - out_ready low stalls the burst indefinitely; cnt is unchanged and no timeout applies.
  - Requests from non-granted requesters are ignored until the next IDLE arbitration; no preemption.
  - MAX_BURST=1 gives one transfer per grant.
  - cnt never exceeds MAX_BURST-1, so it never wraps.
  - ptr wraps 3 -> 0.
  - gnt is always zero or one-hot.
  - busy = (state == GRANT).

Test Plan:
- Reset, then req=0000 for 5 cycles -> gnt=0000, out_valid=0, ack=0000, s1=s0=0 throughout.
- req=0100, out_ready=1, d[2] toggling, MAX_BURST=4 -> gnt=0100, s0=1, s1=0 one cycle after the edge; 4 ack[2] pulses; out_data tracks d[2]; then 1 IDLE cycle; regranted with ptr=3.
- req=1111 held, out_ready=1 -> grant order 0,1,2,3,0, each a 4-transfer burst separated by one IDLE cycle; {s0,s1} = 00, 01, 10, 11, 00.
- req=0010 granted, out_ready=0 for 6 cycles, then 1 -> out_valid=1, ack=0000, cnt held during the stall; 4 transfers complete after ready rises.
- req=1001 granted to 0; req[0] drops after 2 transfers -> release at the next edge, 1 IDLE cycle, gnt=1000 with s0=1, s1=1.
- Assert rst mid-burst (after 2 transfers of req1) -> same cycle: gnt=0000, out_valid=0, ack=0000; after release with req1 still high, gnt=0010 and a fresh 4-transfer burst.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one bit-serial output among four requesters.
// Bursts are capped at MAX_BURST, and every release is followed by one IDLE cycle.
module mux4_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d,
  input  logic       out_ready,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       out_data,
  output logic       out_valid,
  output logic [3:0] ack,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [1:0]       cur, ptr, win, idx;
  logic [CNT_W-1:0] cnt;
  logic             xfer, cnt_last, rel;
  logic             m01, m23;

  // Pick the first requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) win = idx;
    end
  end

  // Handshake: a bit moves when out_valid and out_ready are both high at a rising edge;
  // out_valid only reflects req[cur] and never waits on out_ready.
  assign busy      = (state == GRANT);
  assign out_valid = busy & req[cur];
  assign xfer      = out_valid & out_ready;
  assign cnt_last  = (cnt == CNT_W'(MAX_BURST - 1));
  assign rel       = busy & (~req[cur] | (xfer & cnt_last));

  // Two-level mux cell: s1 picks within each pair, s0 picks between the pairs.
  assign m01      = s1 ? d[1] : d[0];
  assign m23      = s1 ? d[3] : d[2];
  assign out_data = s0 ? m23 : m01;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = GRANT;
      GRANT:   if (rel)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack = 4'b0000;
    if (xfer) ack = 4'b0001 << cur;
  end

  // Selects deliberately hold through IDLE so out_data keeps following the last winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= 2'd0;
      ptr <= 2'd0;
      cnt <= '0;
      gnt <= 4'b0000;
      s1  <= 1'b0;
      s0  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            cur <= win;
            gnt <= 4'b0001 << win;
            s0  <= win[1];
            s1  <= win[0];
            cnt <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            gnt <= 4'b0000;
            ptr <= cur + 2'd1;
            cnt <= '0;
          end else if (xfer) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
